ita_requant_stage: RTL and testbench

- Pipelined requantizer between the accumulator array and the output FIFO.
- Consumes one beat of N signed WO-bit accumulator lanes (oup_t) and produces N signed WI-bit lanes (requant_oup_t).
- Per-beat constants come from the ctrl_t arrays eps_mult/right_shift/add, selected by a step index carried with the beat.
- Valid/ready on both sides; full backpressure, no beat loss.

---
 rtl/ita_requant_stage_if.sv | 35 +++
 rtl/ita_requant_stage.sv | 139 +++++++++++++
 tb/tb_ita_requant_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ita_requant_stage_if.sv
// Valid/ready bus for the requantization stage: accumulator beat in,
// per-beat constant tables, requantized beat out and the delivery counter.
interface ita_requant_stage_if #(
  parameter int N                = 16,
  parameter int WO               = 26,
  parameter int WI               = 8,
  parameter int EMS              = 8,
  parameter int N_REQUANT_CONSTS = 8
) ();
  logic                          valid_i;
  logic                          ready_o;
  logic [N*WO-1:0]               data_i;
  logic [2:0]                    idx_i;
  logic                          last_i;
  logic [N_REQUANT_CONSTS*EMS-1:0] eps_mult_i;
  logic [N_REQUANT_CONSTS*EMS-1:0] right_shift_i;
  logic [N_REQUANT_CONSTS*WI-1:0]  add_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [N*WI-1:0]               data_o;
  logic                          last_o;
  logic [15:0]                   beat_cnt_o;

  // Requant stage side
  modport slave (
    input  valid_i, data_i, idx_i, last_i, eps_mult_i, right_shift_i, add_i, ready_i,
    output ready_o, valid_o, data_o, last_o, beat_cnt_o
  );

  // Producer/consumer side
  modport master (
    output valid_i, data_i, idx_i, last_i, eps_mult_i, right_shift_i, add_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, beat_cnt_o
  );
endinterface

// File: rtl/ita_requant_stage.sv
// Two-stage pipelined requantizer: S1 multiplies each accumulator lane by the
// selected eps multiplier, S2 rounds, shifts, adds the offset and saturates.
// Shift and offset travel with the beat so constant updates never disturb
// beats already in flight.
module ita_requant_stage #(
  parameter int N                = 16,
  parameter int WO               = 26,
  parameter int WI               = 8,
  parameter int EMS              = 8,
  parameter int N_REQUANT_CONSTS = 8,
  parameter int UnsignedMode     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ita_requant_stage_if.slave    bus
);

  localparam int PW      = WO + EMS + 1;  // signed lane x zero-extended multiplier
  localparam int RW      = PW + 1;        // headroom for the rounding constant
  localparam int YW      = RW + 1;        // headroom for the offset add
  localparam int SAT_MAX = (UnsignedMode != 0) ? (2**WI) - 1 : (2**(WI-1)) - 1;
  localparam int SAT_MIN = (UnsignedMode != 0) ? 0 : -(2**(WI-1));

  // Round-half-up then arithmetic shift; shifts past the product width
  // collapse to the sign (0 or -1).
  function automatic logic signed [RW-1:0] round_shift(
    input logic signed [PW-1:0] p,
    input logic [EMS-1:0]       s
  );
    int                  si;
    logic signed [RW-1:0] r;
    si = int'(s);
    r  = RW'(p);
    if (si >= PW) return (p < 0) ? '1 : '0;
    if (si >= 1) r = r + (RW'(1) << (si - 1));
    return r >>> si;
  endfunction

  // Clamp to the output lane range (signed or unsigned depending on mode).
  function automatic logic [WI-1:0] saturate(input logic signed [YW-1:0] y);
    if (y > YW'(SAT_MAX)) return WI'(SAT_MAX);
    if (y < YW'(SAT_MIN)) return WI'(SAT_MIN);
    return y[WI-1:0];
  endfunction

  logic                   vld_p1_q, vld_p2_q;
  logic                   last_p1_q, last_p2_q;
  logic [EMS-1:0]         shift_p1_q;
  logic signed [WI-1:0]   add_p1_q;
  logic signed [PW-1:0]   prod_p1_q [N];
  logic signed [PW-1:0]   prod_d    [N];
  logic [N*WI-1:0]        data_p2_q;
  logic [N*WI-1:0]        res_d;
  logic [15:0]            beat_cnt_q;

  logic [EMS-1:0]         mult_sel, shift_sel;
  logic signed [WI-1:0]   add_sel;
  int                     sel;

  logic adv_p1, adv_p2, in_fire, out_fire;

  assign adv_p2   = !vld_p2_q || bus.ready_i;
  assign adv_p1   = !vld_p1_q || adv_p2;
  assign in_fire  = bus.valid_i && adv_p1;
  assign out_fire = vld_p2_q && bus.ready_i;

  // ---- S1 input: constant-set select and per-lane multiply ----
  // Pick the constant set (out-of-range index falls back to set 0) and form products.
  always_comb begin
    sel       = 0;
    mult_sel  = '0;
    shift_sel = '0;
    add_sel   = '0;
    for (int l = 0; l < N; l++) prod_d[l] = '0;
    if (int'(bus.idx_i) < N_REQUANT_CONSTS) sel = int'(bus.idx_i);
    mult_sel  = bus.eps_mult_i[sel*EMS +: EMS];
    shift_sel = bus.right_shift_i[sel*EMS +: EMS];
    add_sel   = $signed(bus.add_i[sel*WI +: WI]);
    for (int l = 0; l < N; l++) begin
      prod_d[l] = PW'($signed(bus.data_i[l*WO +: WO])) * PW'($signed({1'b0, mult_sel}));
    end
  end

  // S1 register: capture products plus the shift/offset that belong to this beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      shift_p1_q <= '0;
      add_p1_q   <= '0;
      prod_p1_q  <= '{default: '0};
    end else begin
      if (adv_p1) vld_p1_q <= bus.valid_i;
      if (in_fire) begin
        last_p1_q  <= bus.last_i;
        shift_p1_q <= shift_sel;
        add_p1_q   <= add_sel;
        prod_p1_q  <= prod_d;
      end
    end
  end

  // ---- S1 -> S2: round, shift, offset, saturate ----
  // Requantize every lane from the S1 products.
  always_comb begin
    res_d = '0;
    for (int l = 0; l < N; l++) begin
      res_d[l*WI +: WI] = saturate(YW'(round_shift(prod_p1_q[l], shift_p1_q)) + YW'(add_p1_q));
    end
  end

  // S2 register: output beat, held while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      data_p2_q <= '0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        data_p2_q <= res_d;
        last_p2_q <= last_p1_q;
      end
    end
  end

  // Count delivered beats (free-running, wraps).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) beat_cnt_q <= '0;
    else if (out_fire) beat_cnt_q <= beat_cnt_q + 16'd1;
  end

  assign bus.ready_o    = adv_p1;
  assign bus.valid_o    = vld_p2_q;
  assign bus.data_o     = data_p2_q;
  assign bus.last_o     = last_p2_q;
  assign bus.beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_ita_requant_stage.sv
// Directed bench for ita_requant_stage: stimulus pushes hand-computed beats
// into scoreboards, independent monitors pop and compare on each output beat.
module tb_ita_requant_stage;
  localparam int N  = 16;
  localparam int WO = 26;
  localparam int WI = 8;
  localparam int EMS = 8;
  localparam int NC = 8;

  typedef struct {
    logic [N*WI-1:0] data;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  ita_requant_stage_if #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .N_REQUANT_CONSTS(NC)) bif ();
  ita_requant_stage_if #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .N_REQUANT_CONSTS(NC)) uif ();

  ita_requant_stage #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .N_REQUANT_CONSTS(NC),
                      .UnsignedMode(0)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bif));
  ita_requant_stage #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .N_REQUANT_CONSTS(NC),
                      .UnsignedMode(1)) dut_u (.clk_i(clk), .rst_ni(rst_ni), .bus(uif));

  exp_t sbq[$];
  exp_t usbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int e0, e1, e2, er, input bit last);
    exp_t e;
    for (int k = 0; k < N; k++) e.data[k*WI +: WI] = WI'(er);
    e.data[0 +: WI]    = WI'(e0);
    e.data[WI +: WI]   = WI'(e1);
    e.data[2*WI +: WI] = WI'(e2);
    e.last = last;
    return e;
  endfunction

  function automatic logic [N*WO-1:0] mk_data(input int l0, l1, l2);
    logic [N*WO-1:0] d;
    d = '0;
    d[0 +: WO]    = WO'(l0);
    d[WO +: WO]   = WO'(l1);
    d[2*WO +: WO] = WO'(l2);
    return d;
  endfunction

  task automatic set_const(input int idx, input int m, input int s, input int a);
    bif.eps_mult_i[idx*EMS +: EMS]    = EMS'(m);
    bif.right_shift_i[idx*EMS +: EMS] = EMS'(s);
    bif.add_i[idx*WI +: WI]           = WI'(a);
  endtask

  // Present one beat; push its expectation at the edge where it is accepted.
  task automatic send(input int l0, l1, l2, e0, e1, e2, er, input int idx, input bit last);
    exp_t e;
    bit   ok;
    int   guard;
    e = mk_exp(e0, e1, e2, er, last);
    bif.valid_i = 1'b1;
    bif.data_i  = mk_data(l0, l1, l2);
    bif.idx_i   = 3'(idx);
    bif.last_i  = last;
    guard = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = bif.ready_o;
      if (ok) sbq.push_back(e);
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) check("send_timeout", 128'(0), 128'(1));
    bif.valid_i = 1'b0;
    bif.last_i  = 1'b0;
  endtask

  task automatic send_u(input int l0, l1, l2, e0, e1, e2, er);
    bit ok;
    int guard;
    uif.valid_i = 1'b1;
    uif.data_i  = mk_data(l0, l1, l2);
    uif.idx_i   = 3'd0;
    guard = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = uif.ready_o;
      if (ok) usbq.push_back(mk_exp(e0, e1, e2, er, 1'b0));
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) check("send_u_timeout", 128'(0), 128'(1));
    uif.valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sbq.size() != 0 || usbq.size() != 0) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sbq.size() != 0 || usbq.size() != 0) check("drain_timeout", 128'(sbq.size()), 128'(0));
  endtask

  // Main monitor: compare each delivered beat, and check holding during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_ni) begin
      exp_cnt = 0;
    end else if (bif.valid_o) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", 128'(bif.valid_o), 128'(0));
      end else if (bif.ready_i) begin
        e = sbq.pop_front();
        check("data_o", 128'(bif.data_o), 128'(e.data));
        check("last_o", 128'(bif.last_o), 128'(e.last));
        check("beat_cnt_o", 128'(bif.beat_cnt_o), 128'(exp_cnt));
        exp_cnt++;
      end else begin
        check("stall_hold", 128'(bif.data_o), 128'(sbq[0].data));
      end
    end
  end

  // Unsigned-mode monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && uif.valid_o) begin
      if (usbq.size() == 0) begin
        check("u_unexpected_beat", 128'(uif.valid_o), 128'(0));
      end else begin
        e = usbq.pop_front();
        check("u_data_o", 128'(uif.data_o), 128'(e.data));
      end
    end
  end

  initial begin
    bif.valid_i = 1'b0; bif.data_i = '0; bif.idx_i = '0; bif.last_i = 1'b0;
    bif.eps_mult_i = '0; bif.right_shift_i = '0; bif.add_i = '0; bif.ready_i = 1'b1;
    uif.valid_i = 1'b0; uif.data_i = '0; uif.idx_i = '0; uif.last_i = 1'b0;
    uif.eps_mult_i = {NC{8'd1}}; uif.right_shift_i = '0; uif.add_i = '0; uif.ready_i = 1'b1;
    for (int i = 0; i < NC; i++) set_const(i, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 128'(bif.valid_o), 128'(0));
    check("rst_data_o", 128'(bif.data_o), 128'(0));
    check("rst_last_o", 128'(bif.last_o), 128'(0));
    check("rst_beat_cnt", 128'(bif.beat_cnt_o), 128'(0));
    rst_ni = 1'b1;
    #1;
    check("rst_ready_o", 128'(bif.ready_o), 128'(1));

    // Pass-through
    send(100, -7, 0, 100, -7, 0, 0, 0, 1'b0);
    drain();
    check("pass_beat_cnt", 128'(bif.beat_cnt_o), 128'(1));

    // Saturation, signed and unsigned
    send(200, -300, -128, 127, -128, -128, 0, 0, 1'b0);
    send_u(-5, 300, 17, 0, 255, 17, 0);
    drain();

    // Rounding, offset and large shifts
    set_const(0, 3, 2, 0);
    send(5, -5, 100, 4, -4, 75, 0, 0, 1'b0);
    set_const(0, 3, 2, -5);
    send(5, -5, 100, -1, -9, 70, -5, 0, 1'b0);
    set_const(0, 3, 40, 0);
    send(-1, 5, 0, -1, 0, 0, 0, 0, 1'b0);
    set_const(0, 3, 35, 2);
    send(-1, 5, 0, 1, 2, 2, 2, 0, 1'b0);
    drain();

    // Index select, and constant change with the beat in S1
    set_const(0, 1, 0, 0);
    set_const(1, 4, 3, 1);
    set_const(2, 7, 2, -3);
    set_const(3, 2, 1, 10);
    send(7, 0, 0, 17, 10, 10, 10, 3, 1'b0);
    set_const(3, 5, 0, -20);
    send(7, 0, 0, 15, -20, -20, -20, 3, 1'b0);
    send(7, -9, 0, 5, -3, 1, 1, 1, 1'b0);
    drain();

    // Backpressure with a fresh counter
    set_const(0, 1, 0, 0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(i*10, -i, i, i*10, -i, i, 0, 0, i == 6);
      end
      begin
        for (int c = 0; c < 8; c++) begin
          bif.ready_i = !(c >= 2 && c <= 5);
          @(negedge clk);
          check($sformatf("bp_ready_o_c%0d", c), 128'(bif.ready_o), 128'(!(c >= 2 && c <= 5)));
          @(posedge clk); #1;
        end
        bif.ready_i = 1'b1;
      end
    join
    drain();
    check("bp_beat_cnt", 128'(bif.beat_cnt_o), 128'(6));

    // Reset mid-stream with two beats in flight
    send(1, 2, 3, 1, 2, 3, 0, 0, 1'b0);
    send(4, 5, 6, 4, 5, 6, 0, 0, 1'b0);
    rst_ni = 1'b0;
    sbq.delete();
    #1;
    check("midrst_valid_o", 128'(bif.valid_o), 128'(0));
    check("midrst_beat_cnt", 128'(bif.beat_cnt_o), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
    check("midrst_ready_o", 128'(bif.ready_o), 128'(1));
    check("midrst_valid_after", 128'(bif.valid_o), 128'(0));
    send(50, 0, 0, 50, 0, 0, 0, 0, 1'b1);
    check("lat_valid_1cyc", 128'(bif.valid_o), 128'(0));
    @(posedge clk); #1;
    check("lat_valid_2cyc", 128'(bif.valid_o), 128'(1));
    drain();
    check("final_beat_cnt", 128'(bif.beat_cnt_o), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
